frame_buffer_scan_controller: RTL and testbench
===============================================

// Module: frame_buffer_scan_controller
// PURPOSE
//  Drives the 3x3-neighbourhood frame buffer from its write/read side. Accepts a raster pixel
//  stream (valid/ready), writes one full P_ROWS x P_COLUMNS frame into the buffer, then sweeps
//  every pixel position in raster order, issuing buffer reads and presenting each returned
//  8-pixel matrix downstream (valid/ready) to the edge-detection kernel. Repeats per frame.
// PARAMETERS
//  P_COLUMNS           640  columns per frame (must match buffer)
//  P_ROWS              4    rows per frame (must match buffer)
//  P_PIXEL_DEPTH       8    bits per pixel
//  P_COLUMNS_BIT_COUNT $clog2(P_COLUMNS)  local; P_ROWS_BIT_COUNT $clog2(P_ROWS)  local
//  P_MATRIX_BIT_COUNT  P_PIXEL_DEPTH*8  local
// PORTS
//  I_CLK                input  1      clock
//  I_RESET_N            input  1      synchronous reset, active-low
//  I_PIXEL              input  DEPTH  upstream pixel, raster order
//  I_PIXEL_VALID        input  1      upstream pixel valid
//  O_PIXEL_READY        output 1      controller accepts pixel (high only in S_FILL)
//  O_BUF_COLUMN         output COLBITS buffer column address
//  O_BUF_ROW            output ROWBITS buffer row address
//  O_BUF_PIXEL          output DEPTH  buffer write data
//  O_BUF_WRITE_ENABLE   output 1      buffer write strobe
//  O_BUF_READ_ENABLE    output 1      buffer read strobe
//  I_BUF_PIXEL_MATRIX   input  MATRIX buffer matrix output {TL,T,TR,ML,MR,BL,B,BR}, TL at MSBs
//  O_MATRIX             output MATRIX matrix presented downstream, same packing
//  O_MATRIX_ROW         output ROWBITS centre-pixel row of O_MATRIX
//  O_MATRIX_COLUMN      output COLBITS centre-pixel column of O_MATRIX
//  O_MATRIX_VALID       output 1      O_MATRIX valid
//  I_MATRIX_READY       input  1      downstream accepts O_MATRIX
//  O_FRAME_DONE         output 1      one-cycle pulse after last matrix of a frame is accepted
// BEHAVIOUR
//  - Reset (I_RESET_N=0 at posedge): state S_FILL, write/read counters (0,0), all registered
//    outputs 0; O_PIXEL_READY=1 the first cycle after reset deasserts. Reset mid-frame aborts
//    everything; partial buffer contents are overwritten by the next fill.
//  - Buffer's own active-high reset is driven at top level from ~I_RESET_N, not by this block.
//  - S_FILL: O_PIXEL_READY=1; O_BUF_WRITE_ENABLE=I_PIXEL_VALID (combinational), O_BUF_PIXEL=I_PIXEL,
//    address=write counters, read enable 0. On each valid&ready: column++, at P_COLUMNS-1 wrap
//    to 0 and row++. Gaps in I_PIXEL_VALID stall counters. Accepting pixel (P_ROWS-1,P_COLUMNS-1)
//    -> S_READ, write counters to (0,0), read counters (0,0).
//  - S_READ (1 cycle): O_BUF_READ_ENABLE=1, write enable 0, address=read counters -> S_CAPTURE.
//  - S_CAPTURE (1 cycle): buffer output now holds the matrix; register I_BUF_PIXEL_MATRIX into
//    O_MATRIX, read counters into O_MATRIX_ROW/COLUMN, set O_MATRIX_VALID -> S_PRESENT.
//  - Latency: read issued cycle N -> O_MATRIX_VALID high cycle N+2. Max rate 1 matrix / 3 cycles.
//  - S_PRESENT: O_MATRIX*, O_MATRIX_VALID stable until I_MATRIX_READY=1 (never withdrawn, never
//    changed while waiting). On handshake: VALID clears next cycle; if read counters at last
//    pixel -> S_DONE, else advance raster counters -> S_READ.
//  - S_DONE (1 cycle): O_FRAME_DONE=1, counters (0,0) -> S_FILL.
//  - Read and write enables are never high together. Outside S_FILL/S_READ both enables are 0
//    and addresses hold last value. O_PIXEL_READY=0 outside S_FILL; I_PIXEL_VALID ignored there.
//  - Edge zeroing (out-of-frame neighbours) is done by the buffer; controller passes data as-is.
//  - Counters never exceed P_COLUMNS-1 / P_ROWS-1; no arithmetic beyond increment-and-wrap.
// STRUCTURE
//  - Shared package: state encoding (S_FILL,S_READ,S_CAPTURE,S_PRESENT,S_DONE), matrix slot
//    index constants (TL=7 .. BR=0) and a slice helper for packing.
//  - Sub-module raster_counter (P_COLUMNS,P_ROWS): enable, clear, row/column outputs, last flag;
//    instantiated twice (write side, read side). FSM and output registers in this module.
// TESTING (P_COLUMNS=4, P_ROWS=3, DEPTH=8, behavioural buffer model attached)
//  1. Hold I_RESET_N=0 3 cycles -> all outputs 0; release -> O_PIXEL_READY=1, matrix valid 0.
//  2. Stream values 1..12 continuous valid -> writes at (0,0)..(2,3) in order; READY low after 12th.
//  3. Sink always ready -> 12 matrices raster order; (0,0)={0,0,0,0,2,0,5,6};
//     (1,1)={1,2,3,5,7,9,10,11}; O_FRAME_DONE one pulse after 12th; READY returns high next cycle.
//  4. I_MATRIX_READY low 5 cycles at (1,1) -> O_MATRIX/ROW/COLUMN stable, no buffer read issued.
//  5. I_PIXEL_VALID toggling 1/0 during fill -> exactly 12 writes, addresses advance only on valid.
//  6. Assert reset while presenting matrix 5 -> VALID 0 next cycle, S_FILL, write address (0,0).

Source files
------------

// File: rtl/frame_buffer_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_scan_controller_pkg
// Description : Shared state encoding, 3x3-matrix slot indices and a slot
//               slicing helper for the frame buffer scan controller.
// Revision    : 1.0  initial release
// ============================================================================
package frame_buffer_scan_controller_pkg;

    // Controller phases: fill the buffer, then read/capture/present per pixel.
    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } scan_state_t;

    // Neighbour slot positions inside a packed matrix, TL in the top slot.
    localparam int unsigned c_slot_tl = 7;
    localparam int unsigned c_slot_t  = 6;
    localparam int unsigned c_slot_tr = 5;
    localparam int unsigned c_slot_ml = 4;
    localparam int unsigned c_slot_mr = 3;
    localparam int unsigned c_slot_bl = 2;
    localparam int unsigned c_slot_b  = 1;
    localparam int unsigned c_slot_br = 0;

    // Bit offset of a neighbour slot for a given pixel depth.
    function automatic int unsigned slot_lsb(input int unsigned slot,
                                             input int unsigned depth);
        return slot * depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_scan_controller_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Row/column raster position counter with increment-and-wrap,
//               synchronous clear and a last-position flag.
// Revision    : 1.0  initial release
// ============================================================================
module raster_counter
    import frame_buffer_scan_controller_pkg::*;
#(
    parameter int P_COLUMNS = 640,
    parameter int P_ROWS    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_enable,
    input  logic                        i_clear,
    output logic [$clog2(P_ROWS)-1:0]    o_row,
    output logic [$clog2(P_COLUMNS)-1:0] o_column,
    output logic                        o_last
);

    localparam int c_col_bits = $clog2(P_COLUMNS);
    localparam int c_row_bits = $clog2(P_ROWS);
    localparam logic [c_col_bits-1:0] c_col_last = c_col_bits'(P_COLUMNS - 1);
    localparam logic [c_row_bits-1:0] c_row_last = c_row_bits'(P_ROWS - 1);

    logic [c_row_bits-1:0] r_row;
    logic [c_col_bits-1:0] r_column;

    // Advance one pixel in raster order; the last pixel wraps back to (0,0).
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_row    <= '0;
            r_column <= '0;
        end else if (i_enable) begin
            if (r_column == c_col_last) begin
                r_column <= '0;
                if (r_row == c_row_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_column <= r_column + 1'b1;
            end
        end
    end

    assign o_row    = r_row;
    assign o_column = r_column;
    assign o_last   = (r_row == c_row_last) && (r_column == c_col_last);

endmodule
`default_nettype wire

// File: rtl/frame_buffer_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_scan_controller
// Description : Fills the 3x3-neighbourhood frame buffer with one raster frame,
//               then sweeps every pixel, reading each neighbourhood matrix and
//               presenting it downstream with a valid/ready handshake.
// Revision    : 1.0  initial release
// ============================================================================
module frame_buffer_scan_controller
    import frame_buffer_scan_controller_pkg::*;
#(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 4,
    parameter int P_PIXEL_DEPTH = 8,
    localparam int P_COLUMNS_BIT_COUNT = $clog2(P_COLUMNS),
    localparam int P_ROWS_BIT_COUNT    = $clog2(P_ROWS),
    localparam int P_MATRIX_BIT_COUNT  = P_PIXEL_DEPTH * 8
) (
    input  logic                           I_CLK,
    input  logic                           I_RESET_N,
    input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
    input  logic                           I_PIXEL_VALID,
    output logic                           O_PIXEL_READY,
    output logic [P_COLUMNS_BIT_COUNT-1:0] O_BUF_COLUMN,
    output logic [P_ROWS_BIT_COUNT-1:0]    O_BUF_ROW,
    output logic [P_PIXEL_DEPTH-1:0]       O_BUF_PIXEL,
    output logic                           O_BUF_WRITE_ENABLE,
    output logic                           O_BUF_READ_ENABLE,
    input  logic [P_MATRIX_BIT_COUNT-1:0]  I_BUF_PIXEL_MATRIX,
    output logic [P_MATRIX_BIT_COUNT-1:0]  O_MATRIX,
    output logic [P_ROWS_BIT_COUNT-1:0]    O_MATRIX_ROW,
    output logic [P_COLUMNS_BIT_COUNT-1:0] O_MATRIX_COLUMN,
    output logic                           O_MATRIX_VALID,
    input  logic                           I_MATRIX_READY,
    output logic                           O_FRAME_DONE
);

    scan_state_t r_state;
    scan_state_t w_state_next;

    logic [P_ROWS_BIT_COUNT-1:0]    w_wr_row;
    logic [P_COLUMNS_BIT_COUNT-1:0] w_wr_column;
    logic                           w_wr_last;
    logic [P_ROWS_BIT_COUNT-1:0]    w_rd_row;
    logic [P_COLUMNS_BIT_COUNT-1:0] w_rd_column;
    logic                           w_rd_last;
    logic                           w_fill;
    logic                           w_pixel_accept;
    logic                           w_matrix_accept;
    logic                           w_done;

    logic [P_ROWS_BIT_COUNT-1:0]    r_addr_row;
    logic [P_COLUMNS_BIT_COUNT-1:0] r_addr_column;
    logic [P_MATRIX_BIT_COUNT-1:0]  r_matrix;
    logic [P_ROWS_BIT_COUNT-1:0]    r_matrix_row;
    logic [P_COLUMNS_BIT_COUNT-1:0] r_matrix_column;
    logic                           r_matrix_valid;

    // Fill is gated by reset so the write side stays quiet while reset is held.
    assign w_fill          = (r_state == S_FILL) && I_RESET_N;
    assign w_pixel_accept  = w_fill && I_PIXEL_VALID;
    assign w_matrix_accept = (r_state == S_PRESENT) && I_MATRIX_READY;
    assign w_done          = (r_state == S_DONE);

    // Write-side position: wraps to (0,0) on the last pixel of the frame.
    raster_counter #(
        .P_COLUMNS (P_COLUMNS),
        .P_ROWS    (P_ROWS)
    ) u_write_counter (
        .clk      (I_CLK),
        .rst_n    (I_RESET_N),
        .i_enable (w_pixel_accept),
        .i_clear  (w_done),
        .o_row    (w_wr_row),
        .o_column (w_wr_column),
        .o_last   (w_wr_last)
    );

    // Read-side position: advances once per accepted downstream matrix.
    raster_counter #(
        .P_COLUMNS (P_COLUMNS),
        .P_ROWS    (P_ROWS)
    ) u_read_counter (
        .clk      (I_CLK),
        .rst_n    (I_RESET_N),
        .i_enable (w_matrix_accept),
        .i_clear  (w_done),
        .o_row    (w_rd_row),
        .o_column (w_rd_column),
        .o_last   (w_rd_last)
    );

    // State register.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and buffer-side strobes; addresses hold outside fill/read.
    always_comb begin
        w_state_next       = r_state;
        O_PIXEL_READY      = w_fill;
        O_BUF_WRITE_ENABLE = 1'b0;
        O_BUF_READ_ENABLE  = 1'b0;
        O_BUF_PIXEL        = '0;
        O_BUF_ROW          = r_addr_row;
        O_BUF_COLUMN       = r_addr_column;
        O_FRAME_DONE       = 1'b0;
        case (r_state)
            S_FILL: begin
                O_BUF_WRITE_ENABLE = w_pixel_accept;
                O_BUF_PIXEL        = w_fill ? I_PIXEL : '0;
                O_BUF_ROW          = w_wr_row;
                O_BUF_COLUMN       = w_wr_column;
                if (w_pixel_accept && w_wr_last) begin
                    w_state_next = S_READ;
                end
            end
            S_READ: begin
                O_BUF_READ_ENABLE = 1'b1;
                O_BUF_ROW         = w_rd_row;
                O_BUF_COLUMN      = w_rd_column;
                w_state_next      = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (I_MATRIX_READY) begin
                    w_state_next = w_rd_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                O_FRAME_DONE = 1'b1;
                w_state_next = S_FILL;
            end
            default: begin
                w_state_next = S_FILL;
            end
        endcase
    end

    // Held buffer address, plus the downstream matrix register and its valid.
    always_ff @(posedge I_CLK) begin
        if (!I_RESET_N) begin
            r_addr_row      <= '0;
            r_addr_column   <= '0;
            r_matrix        <= '0;
            r_matrix_row    <= '0;
            r_matrix_column <= '0;
            r_matrix_valid  <= 1'b0;
        end else begin
            r_addr_row    <= O_BUF_ROW;
            r_addr_column <= O_BUF_COLUMN;
            if (r_state == S_CAPTURE) begin
                r_matrix        <= I_BUF_PIXEL_MATRIX;
                r_matrix_row    <= w_rd_row;
                r_matrix_column <= w_rd_column;
                r_matrix_valid  <= 1'b1;
            end else if (w_matrix_accept) begin
                r_matrix_valid <= 1'b0;
            end
        end
    end

    assign O_MATRIX        = r_matrix;
    assign O_MATRIX_ROW    = r_matrix_row;
    assign O_MATRIX_COLUMN = r_matrix_column;
    assign O_MATRIX_VALID  = r_matrix_valid;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_scan_controller
// Description : Self-checking bench for frame_buffer_scan_controller on a
//               4x3 frame with a behavioural neighbourhood buffer attached.
// Revision    : 1.0  initial release
// ============================================================================
module tb_frame_buffer_scan_controller;
    import frame_buffer_scan_controller_pkg::*;

    localparam int c_cols = 4;
    localparam int c_rows = 3;

    logic        I_CLK;
    logic        I_RESET_N;
    logic [7:0]  I_PIXEL;
    logic        I_PIXEL_VALID;
    logic        O_PIXEL_READY;
    logic [1:0]  O_BUF_COLUMN;
    logic [1:0]  O_BUF_ROW;
    logic [7:0]  O_BUF_PIXEL;
    logic        O_BUF_WRITE_ENABLE;
    logic        O_BUF_READ_ENABLE;
    logic [63:0] I_BUF_PIXEL_MATRIX;
    logic [63:0] O_MATRIX;
    logic [1:0]  O_MATRIX_ROW;
    logic [1:0]  O_MATRIX_COLUMN;
    logic        O_MATRIX_VALID;
    logic        I_MATRIX_READY;
    logic        O_FRAME_DONE;

    int total = 0;
    int bad   = 0;

    frame_buffer_scan_controller #(
        .P_COLUMNS     (c_cols),
        .P_ROWS        (c_rows),
        .P_PIXEL_DEPTH (8)
    ) dut (
        .I_CLK              (I_CLK),
        .I_RESET_N          (I_RESET_N),
        .I_PIXEL            (I_PIXEL),
        .I_PIXEL_VALID      (I_PIXEL_VALID),
        .O_PIXEL_READY      (O_PIXEL_READY),
        .O_BUF_COLUMN       (O_BUF_COLUMN),
        .O_BUF_ROW          (O_BUF_ROW),
        .O_BUF_PIXEL        (O_BUF_PIXEL),
        .O_BUF_WRITE_ENABLE (O_BUF_WRITE_ENABLE),
        .O_BUF_READ_ENABLE  (O_BUF_READ_ENABLE),
        .I_BUF_PIXEL_MATRIX (I_BUF_PIXEL_MATRIX),
        .O_MATRIX           (O_MATRIX),
        .O_MATRIX_ROW       (O_MATRIX_ROW),
        .O_MATRIX_COLUMN    (O_MATRIX_COLUMN),
        .O_MATRIX_VALID     (O_MATRIX_VALID),
        .I_MATRIX_READY     (I_MATRIX_READY),
        .O_FRAME_DONE       (O_FRAME_DONE)
    );

    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural neighbourhood buffer ----------------
    logic [7:0] mem [0:c_rows-1][0:c_cols-1];
    logic       s_we = 1'b0;
    logic       s_re = 1'b0;
    logic [1:0] s_row, s_col;
    logic [7:0] s_pix;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic [7:0] pix;
    } wr_t;
    wr_t wlog[$];

    function automatic logic [7:0] px(input int r, input int c);
        if (r < 0 || r >= c_rows || c < 0 || c >= c_cols) return 8'd0;
        return mem[r][c];
    endfunction

    function automatic logic [63:0] nbr(input int r, input int c);
        return {px(r-1, c-1), px(r-1, c), px(r-1, c+1), px(r, c-1),
                px(r, c+1), px(r+1, c-1), px(r+1, c), px(r+1, c+1)};
    endfunction

    // Sample buffer-side strobes mid-cycle, apply them on the next rising edge.
    always @(negedge I_CLK) begin
        s_we  = O_BUF_WRITE_ENABLE;
        s_re  = O_BUF_READ_ENABLE;
        s_row = O_BUF_ROW;
        s_col = O_BUF_COLUMN;
        s_pix = O_BUF_PIXEL;
        if (O_BUF_WRITE_ENABLE === 1'b1) wlog.push_back('{O_BUF_ROW, O_BUF_COLUMN, O_BUF_PIXEL});
        chk("rw_exclusive", {62'd0, O_BUF_WRITE_ENABLE, O_BUF_READ_ENABLE} == 64'd3 ? 64'd1 : 64'd0, 64'd0);
    end

    always @(posedge I_CLK) begin
        if (s_we && s_row < c_rows) mem[s_row][s_col] <= s_pix;
        if (s_re) I_BUF_PIXEL_MATRIX <= nbr(int'(s_row), int'(s_col));
    end

    // ---------------- expected matrices ----------------
    typedef struct {
        int          stall;
        logic [1:0]  row;
        logic [1:0]  col;
        logic [63:0] mat;
    } vec_t;
    vec_t vecs [12];

    function automatic vec_t mkv(input int stall, input int r, input int c,
                                 input logic [7:0] tl, t, tr, ml, mr, bl, b, br);
        vec_t v;
        v.stall = stall;
        v.row   = 2'(r);
        v.col   = 2'(c);
        v.mat   = '0;
        v.mat[slot_lsb(c_slot_tl, 8) +: 8] = tl;
        v.mat[slot_lsb(c_slot_t,  8) +: 8] = t;
        v.mat[slot_lsb(c_slot_tr, 8) +: 8] = tr;
        v.mat[slot_lsb(c_slot_ml, 8) +: 8] = ml;
        v.mat[slot_lsb(c_slot_mr, 8) +: 8] = mr;
        v.mat[slot_lsb(c_slot_bl, 8) +: 8] = bl;
        v.mat[slot_lsb(c_slot_b,  8) +: 8] = b;
        v.mat[slot_lsb(c_slot_br, 8) +: 8] = br;
        return v;
    endfunction

    task automatic step();
        @(posedge I_CLK);
        #1;
    endtask

    // Stream pixels 1..12; optionally insert a one-cycle valid gap after each.
    task automatic fill(input bit gaps);
        wlog.delete();
        for (int k = 0; k < 12; k++) begin
            I_PIXEL       = 8'(k + 1);
            I_PIXEL_VALID = 1'b1;
            step();
            if (gaps && k < 11) begin
                I_PIXEL_VALID = 1'b0;
                I_PIXEL       = 8'hEE;
                #1;
                chk("gap_no_write", {63'd0, O_BUF_WRITE_ENABLE}, 64'd0);
                chk("gap_addr", {60'd0, O_BUF_ROW, O_BUF_COLUMN},
                    {60'd0, 2'((k + 1) / c_cols), 2'((k + 1) % c_cols)});
                step();
            end
        end
        I_PIXEL_VALID = 1'b0;
        I_PIXEL       = 8'h00;
        #1;
        chk("ready_low_after_fill", {63'd0, O_PIXEL_READY}, 64'd0);
        chk("write_count", 64'(wlog.size()), 64'd12);
        for (int k = 0; k < wlog.size() && k < 12; k++) begin
            chk("write_addr", {60'd0, wlog[k].row, wlog[k].col},
                {60'd0, 2'(k / c_cols), 2'(k % c_cols)});
            chk("write_data", {56'd0, wlog[k].pix}, 64'(k + 1));
        end
    endtask

    // Collect n matrices in raster order; the last one is left unaccepted if asked.
    task automatic sweep(input int n, input bit accept_last);
        for (int i = 0; i < n; i++) begin
            int          waited;
            bit          seen;
            bit          hold_last;
            logic [63:0] snap;
            waited    = 0;
            seen      = 1'b0;
            hold_last = (i == n - 1) && !accept_last;
            I_MATRIX_READY = 1'b0;
            while (!seen && waited < 12) begin
                step();
                waited++;
                if (O_MATRIX_VALID === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                chk("matrix_valid_timeout", 64'd0, 64'd1);
                return;
            end
            chk("latency", 64'(waited), 64'd2);
            chk("matrix_pos", {60'd0, O_MATRIX_ROW, O_MATRIX_COLUMN},
                {60'd0, vecs[i].row, vecs[i].col});
            chk("matrix_data", O_MATRIX, vecs[i].mat);
            snap = O_MATRIX;
            if (!hold_last) begin
                for (int k = 0; k < vecs[i].stall; k++) begin
                    step();
                    chk("stall_valid", {63'd0, O_MATRIX_VALID}, 64'd1);
                    chk("stall_data", O_MATRIX, snap);
                    chk("stall_pos", {60'd0, O_MATRIX_ROW, O_MATRIX_COLUMN},
                        {60'd0, vecs[i].row, vecs[i].col});
                    chk("stall_no_read", {63'd0, O_BUF_READ_ENABLE}, 64'd0);
                end
                I_MATRIX_READY = 1'b1;
                step();
                I_MATRIX_READY = 1'b0;
                chk("valid_clears", {63'd0, O_MATRIX_VALID}, 64'd0);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 0,  2, 0,  5,  6);
        vecs[1]  = mkv(0, 0, 1, 0, 0, 0, 1,  3, 5,  6,  7);
        vecs[2]  = mkv(0, 0, 2, 0, 0, 0, 2,  4, 6,  7,  8);
        vecs[3]  = mkv(0, 0, 3, 0, 0, 0, 3,  0, 7,  8,  0);
        vecs[4]  = mkv(0, 1, 0, 0, 1, 2, 0,  6, 0,  9, 10);
        vecs[5]  = mkv(5, 1, 1, 1, 2, 3, 5,  7, 9, 10, 11);
        vecs[6]  = mkv(0, 1, 2, 2, 3, 4, 6,  8, 10, 11, 12);
        vecs[7]  = mkv(0, 1, 3, 3, 4, 0, 7,  0, 11, 12, 0);
        vecs[8]  = mkv(0, 2, 0, 0, 5, 6, 0, 10, 0,  0,  0);
        vecs[9]  = mkv(0, 2, 1, 5, 6, 7, 9, 11, 0,  0,  0);
        vecs[10] = mkv(0, 2, 2, 6, 7, 8, 10, 12, 0, 0,  0);
        vecs[11] = mkv(0, 2, 3, 7, 8, 0, 11, 0, 0,  0,  0);

        I_RESET_N      = 1'b0;
        I_PIXEL        = 8'h00;
        I_PIXEL_VALID  = 1'b0;
        I_MATRIX_READY = 1'b0;

        // Reset held for three cycles: everything quiet.
        repeat (3) step();
        chk("rst_pixel_ready", {63'd0, O_PIXEL_READY}, 64'd0);
        chk("rst_write_en", {63'd0, O_BUF_WRITE_ENABLE}, 64'd0);
        chk("rst_read_en", {63'd0, O_BUF_READ_ENABLE}, 64'd0);
        chk("rst_buf_addr", {60'd0, O_BUF_ROW, O_BUF_COLUMN}, 64'd0);
        chk("rst_buf_pixel", {56'd0, O_BUF_PIXEL}, 64'd0);
        chk("rst_matrix", O_MATRIX, 64'd0);
        chk("rst_matrix_pos", {60'd0, O_MATRIX_ROW, O_MATRIX_COLUMN}, 64'd0);
        chk("rst_matrix_valid", {63'd0, O_MATRIX_VALID}, 64'd0);
        chk("rst_frame_done", {63'd0, O_FRAME_DONE}, 64'd0);
        I_RESET_N = 1'b1;
        #1;
        chk("release_ready", {63'd0, O_PIXEL_READY}, 64'd1);
        chk("release_valid", {63'd0, O_MATRIX_VALID}, 64'd0);

        // Frame 1: continuous fill, full sweep with a stall at (1,1).
        fill(1'b0);
        sweep(12, 1'b1);
        chk("frame_done_pulse", {63'd0, O_FRAME_DONE}, 64'd1);
        chk("done_ready_low", {63'd0, O_PIXEL_READY}, 64'd0);
        step();
        chk("frame_done_clears", {63'd0, O_FRAME_DONE}, 64'd0);
        chk("ready_returns", {63'd0, O_PIXEL_READY}, 64'd1);

        // Frame 2: gapped fill, reset while the fifth matrix is presented.
        fill(1'b1);
        sweep(5, 1'b0);
        I_RESET_N = 1'b0;
        step();
        chk("abort_valid", {63'd0, O_MATRIX_VALID}, 64'd0);
        chk("abort_addr", {60'd0, O_BUF_ROW, O_BUF_COLUMN}, 64'd0);
        chk("abort_read_en", {63'd0, O_BUF_READ_ENABLE}, 64'd0);
        chk("abort_frame_done", {63'd0, O_FRAME_DONE}, 64'd0);
        I_RESET_N = 1'b1;
        #1;
        chk("abort_ready", {63'd0, O_PIXEL_READY}, 64'd1);

        // Frame 3: buffer fully rewritten after the aborted frame.
        fill(1'b0);
        sweep(12, 1'b1);
        chk("frame3_done", {63'd0, O_FRAME_DONE}, 64'd1);
        step();
        chk("frame3_ready", {63'd0, O_PIXEL_READY}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
